rvm_mem_bridge: RTL and testbench

RVM_MEM_BRIDGE -- requirements
Module: rvm_mem_bridge

---
 rtl/rvm_mem_bridge.sv | 138 +++++++++++++
 tb/tb_rvm_mem_bridge.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvm_mem_bridge.sv
// rvm_mem_bridge: bridges a stalling core memory port onto a synchronous SRAM
// with a configurable number of wait cycles. Requests outside the mapped
// window or not word-aligned complete as a one-cycle error.
module rvm_mem_bridge #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter logic [31:0] MEM_SIZE    = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_c_en,
    input  logic [3:0]  mem_b_en,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        mem_stall,
    output logic [29:0] ram_addr,
    output logic        ram_cs,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

    localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);
    // End bound at 33 bits so a window ending exactly at 2^32 stays legal.
    localparam logic [32:0] MemEnd   = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_ben;
    logic [31:0] r_rdata;

    state_e      w_state_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [29:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;
    logic [3:0]  w_ben_nxt;
    logic [31:0] w_rdata_nxt;

    logic        w_legal;
    logic        w_last;
    logic [29:0] w_word;

    assign w_legal = ({1'b0, mem_addr} >= {1'b0, MEM_BASE}) &&
                     ({1'b0, mem_addr} < MemEnd) &&
                     (mem_addr[1:0] == 2'b00);
    assign w_word  = 30'((mem_addr - MEM_BASE) >> 2);
    assign w_last  = (r_cnt == 4'd0);

    // State and latched-request registers; reset returns everything to idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_addr  <= 30'd0;
            r_wdata <= 32'd0;
            r_ben   <= 4'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_ben   <= w_ben_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

    // Next-state: latch request in idle, count down wait cycles, capture read data.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_ben_nxt   = r_ben;
        w_rdata_nxt = r_rdata;
        unique case (r_state)
            StIdle: begin
                if (mem_c_en) begin
                    w_addr_nxt  = w_word;
                    w_wdata_nxt = mem_wdata;
                    w_ben_nxt   = mem_b_en;
                    if (w_legal) begin
                        w_state_nxt = StAccess;
                        w_cnt_nxt   = WaitLoad;
                    end else begin
                        // Cleared on entry so the error cycle already shows zero.
                        w_state_nxt = StErr;
                        w_rdata_nxt = 32'd0;
                    end
                end
            end
            StAccess: begin
                if (w_last) begin
                    if (r_ben == 4'b0000) begin
                        w_rdata_nxt = ram_rdata;
                    end
                    w_state_nxt = StDone;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            StDone:  w_state_nxt = StIdle;
            StErr:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Outputs decoded from state plus latched request.
    always_comb begin
        mem_stall = 1'b0;
        mem_error = 1'b0;
        ram_cs    = 1'b0;
        ram_we    = 4'b0000;
        unique case (r_state)
            StIdle:   mem_stall = mem_c_en;
            StAccess: begin
                mem_stall = 1'b1;
                ram_cs    = 1'b1;
                // Strobes only in the final wait cycle so each write commits once.
                ram_we    = w_last ? r_ben : 4'b0000;
            end
            StDone:   mem_error = 1'b0;
            StErr:    mem_error = 1'b1;
            default:  mem_stall = 1'b0;
        endcase
    end

    assign mem_rdata = r_rdata;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_rvm_mem_bridge.sv
// Scoreboard bench for rvm_mem_bridge: the driver pushes the expected response
// of each request; a monitor observes the SRAM side and the core response.
module tb_rvm_mem_bridge;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_c_en;
    logic [3:0]  mem_b_en;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        mem_stall;
    logic [29:0] ram_addr;
    logic        ram_cs;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // Extra instances for wait-count extremes.
    logic        c0_en, c15_en;
    logic [31:0] x0_rdata, x15_rdata, x_ram_rdata;
    logic        x0_error, x15_error, x0_stall, x15_stall;
    logic [29:0] x0_raddr, x15_raddr;
    logic        x0_cs, x15_cs;
    logic [3:0]  x0_we, x15_we;
    logic [31:0] x0_wdata, x15_wdata;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          stall;
        int          cs;
        int          we_cnt;
        logic [3:0]  we;
        logic [29:0] addr;
        logic [31:0] wdata;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    rvm_mem_bridge #(.WAIT_CYCLES(1)) u_dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_c_en(mem_c_en), .mem_b_en(mem_b_en), .mem_rdata(mem_rdata),
        .mem_error(mem_error), .mem_stall(mem_stall), .ram_addr(ram_addr),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    rvm_mem_bridge #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_c_en(c0_en), .mem_b_en(mem_b_en), .mem_rdata(x0_rdata),
        .mem_error(x0_error), .mem_stall(x0_stall), .ram_addr(x0_raddr),
        .ram_cs(x0_cs), .ram_we(x0_we), .ram_wdata(x0_wdata), .ram_rdata(x_ram_rdata)
    );

    rvm_mem_bridge #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_c_en(c15_en), .mem_b_en(mem_b_en), .mem_rdata(x15_rdata),
        .mem_error(x15_error), .mem_stall(x15_stall), .ram_addr(x15_raddr),
        .ram_cs(x15_cs), .ram_we(x15_we), .ram_wdata(x15_wdata), .ram_rdata(x_ram_rdata)
    );

    assign x_ram_rdata = 32'h0BAD_CAFE;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Small SRAM model with combinational read and byte-strobed write.
    logic [31:0] sram [0:63];
    bit          sram_init = 1'b0;
    assign ram_rdata = sram[ram_addr[5:0]];

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 64; i++) sram[i] <= 32'd0;
            sram[4]   <= 32'hDEAD_BEEF;
            sram[10]  <= 32'h7777_7777;
            sram[63]  <= 32'h600D_F00D;
            sram_init <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) sram[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts stall/cs/we cycles and checks the response on the stall fall.
    int          m_stall, m_cs, m_we, we_total;
    logic [3:0]  m_we_val;
    logic [29:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_prev;

    initial begin
        m_stall = 0; m_cs = 0; m_we = 0; we_total = 0; m_prev = 1'b0;
        m_we_val = 4'd0; m_addr = 30'd0; m_wdata = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            if (ram_we != 4'b0000) we_total++;
            if (reset) begin
                m_stall = 0; m_cs = 0; m_we = 0; m_prev = 1'b0;
            end else begin
                if (ram_cs) begin
                    if (m_cs == 0) m_addr = ram_addr;
                    m_cs++;
                end
                if (ram_we != 4'b0000) begin
                    m_we++;
                    m_we_val = ram_we;
                    m_wdata  = ram_wdata;
                end
                if (mem_stall) m_stall++;
                if (m_prev && !mem_stall) begin
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_response: got error=%0b expected none",
                                 mem_error);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk({e.name, "/error"}, {31'd0, mem_error}, {31'd0, e.err});
                        chk({e.name, "/rdata"}, mem_rdata, e.rdata);
                        chk({e.name, "/stall_cycles"}, m_stall, e.stall);
                        chk({e.name, "/cs_cycles"}, m_cs, e.cs);
                        chk({e.name, "/we_pulses"}, m_we, e.we_cnt);
                        if (e.cs > 0) chk({e.name, "/ram_addr"}, {2'b0, m_addr}, {2'b0, e.addr});
                        if (e.we_cnt > 0) begin
                            chk({e.name, "/ram_we"}, {28'd0, m_we_val}, {28'd0, e.we});
                            chk({e.name, "/ram_wdata"}, m_wdata, e.wdata);
                        end
                    end
                    m_stall = 0; m_cs = 0; m_we = 0;
                end
                m_prev = mem_stall;
            end
        end
    end

    // Issue one request at a negedge; returns at the negedge after the response.
    task automatic do_txn(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] ben, input bit drop, input logic exp_err,
                          input logic [31:0] exp_rdata);
        exp_t e;
        bit   done;
        e.err    = exp_err;
        e.rdata  = exp_rdata;
        e.stall  = exp_err ? 1 : 3;
        e.cs     = exp_err ? 0 : 2;
        e.we_cnt = (!exp_err && ben != 4'b0000) ? 1 : 0;
        e.we     = ben;
        e.addr   = addr[31:2];
        e.wdata  = wdata;
        e.name   = name;
        sb_q.push_back(e);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_b_en  = ben;
        mem_c_en  = 1'b1;
        @(negedge clk);
        // Scramble inputs after the latch cycle; the transaction must not notice.
        mem_addr  = 32'h0000_0030;
        mem_wdata = ~wdata;
        mem_b_en  = ~ben;
        if (drop) mem_c_en = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!mem_stall) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        mem_c_en = 1'b0;
        mem_b_en = 4'b0000;
        if (!done) chk({name, "/timeout"}, 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic measure(input bit big, input int exp_stall, input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        mem_addr = 32'h0000_0010;
        mem_b_en = 4'b0000;
        if (big) c15_en = 1'b1; else c0_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (big ? x15_stall : x0_stall) begin
                n++;
                @(negedge clk);
            end else begin
                done = 1'b1;
                break;
            end
        end
        c0_en = 1'b0;
        c15_en = 1'b0;
        chk({name, "/completed"}, {31'd0, done}, 32'd1);
        chk({name, "/stall_cycles"}, n, exp_stall);
        chk({name, "/error"}, {31'd0, big ? x15_error : x0_error}, 32'd0);
        chk({name, "/rdata"}, big ? x15_rdata : x0_rdata, 32'h0BAD_CAFE);
        @(negedge clk);
    endtask

    initial begin
        int we_before;
        reset = 1'b1; mem_c_en = 1'b0; c0_en = 1'b0; c15_en = 1'b0;
        mem_addr = 32'd0; mem_wdata = 32'd0; mem_b_en = 4'd0;
        @(negedge clk);
        #1;
        chk("reset/ram_cs", {31'd0, ram_cs}, 32'd0);
        chk("reset/ram_we", {28'd0, ram_we}, 32'd0);
        chk("reset/mem_error", {31'd0, mem_error}, 32'd0);
        chk("reset/mem_rdata", mem_rdata, 32'd0);
        chk("reset/stall_idle", {31'd0, mem_stall}, 32'd0);
        mem_c_en = 1'b1;
        #1;
        chk("reset/stall_follows_cen", {31'd0, mem_stall}, 32'd1);
        mem_c_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_txn("rd_0x10",      32'h10,    32'h0,         4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF);
        do_txn("wr_0x20",      32'h20,    32'h1234_5678, 4'b0011, 1'b0, 1'b0, 32'hDEAD_BEEF);
        do_txn("rd_0x20",      32'h20,    32'h0,         4'b0000, 1'b0, 1'b0, 32'h0000_5678);
        do_txn("rd_out_range", 32'h10000, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h0);
        do_txn("rd_0x10_b",    32'h10,    32'h0,         4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF);
        do_txn("rd_misalign",  32'h13,    32'h0,         4'b0000, 1'b0, 1'b1, 32'h0);
        do_txn("wr_0x24_drop", 32'h24,    32'hCAFE_F00D, 4'b1111, 1'b1, 1'b0, 32'h0);
        do_txn("rd_0x24",      32'h24,    32'h0,         4'b0000, 1'b0, 1'b0, 32'hCAFE_F00D);
        do_txn("rd_last_word", 32'hFFFC,  32'h0,         4'b0000, 1'b0, 1'b0, 32'h600D_F00D);

        // Reset during the first wait cycle of a write: the write must never commit.
        we_before = we_total;
        mem_addr = 32'h28; mem_wdata = 32'h1111_1111; mem_b_en = 4'b1111; mem_c_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid/in_access", {31'd0, ram_cs}, 32'd1);
        reset = 1'b1;
        mem_c_en = 1'b0;
        #1;
        chk("rst_mid/ram_cs", {31'd0, ram_cs}, 32'd0);
        chk("rst_mid/ram_we", {28'd0, ram_we}, 32'd0);
        chk("rst_mid/mem_error", {31'd0, mem_error}, 32'd0);
        chk("rst_mid/mem_rdata", mem_rdata, 32'd0);
        chk("rst_mid/mem_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_b_en = 4'b0000;
        @(negedge clk);
        chk("rst_mid/no_we_pulse", we_total, we_before);

        do_txn("rd_0x28_after_rst", 32'h28, 32'h0,   4'b0000, 1'b0, 1'b0, 32'h7777_7777);
        do_txn("rd_0x10_after_rst", 32'h10, 32'h0,   4'b0000, 1'b0, 1'b0, 32'hDEAD_BEEF);
        do_txn("wr_misalign",       32'h22, 32'hFFFF_FFFF, 4'b1111, 1'b0, 1'b1, 32'h0);
        do_txn("rd_0x20_unchanged", 32'h20, 32'h0,   4'b0000, 1'b0, 1'b0, 32'h0000_5678);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);

        measure(1'b0, 2, "wait0");
        measure(1'b1, 17, "wait15");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
